// File: rtl/signed_shift_pipe.sv
// Pipelined signed shifter: ASL (with overflow flag and optional saturation), ASR, LSR, ROL.
// The log2(WIDTH) barrel levels are spread over STAGES registers behind a valid/ready handshake.
module signed_shift_pipe #(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [$clog2(WIDTH)-1:0] in_sh,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_of
);

  localparam int LOG   = $clog2(WIDTH);
  localparam int BASE  = LOG / STAGES;
  localparam int EXTRA = LOG % STAGES;

  typedef enum logic [1:0] {
    MODE_ASL = 2'b00,
    MODE_ASR = 2'b01,
    MODE_LSR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  logic advance;

  // The whole pipe moves as one; bubbles are kept rather than collapsed.
  assign advance   = !gStage[STAGES-1].valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = gStage[STAGES-1].valid_q;
  assign out_data  = gStage[STAGES-1].data_q;
  assign out_of    = gStage[STAGES-1].of_q;

  for (genvar s = 0; s < STAGES; s++) begin : gStage
    // Earlier stages take the extra level when LOG does not divide evenly.
    localparam int FIRST   = s * BASE + ((s < EXTRA) ? s : EXTRA);
    localparam int LAST    = FIRST + BASE + ((s < EXTRA) ? 1 : 0);
    localparam bit IS_LAST = (s == STAGES - 1);

    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             of_in;
    logic [LOG-1:0]   sh_in;
    mode_e            mode_in;
    logic             sign_in;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             of_q;
    logic [WIDTH-1:0] data_d;
    logic             of_d;
    logic signed [WIDTH-1:0] top;

    if (s == 0) begin : gHead
      assign valid_in = in_valid;
      assign data_in  = in_a;
      assign of_in    = 1'b0;
      assign sh_in    = in_sh;
      assign mode_in  = mode_e'(in_mode);
      assign sign_in  = in_a[WIDTH-1];
    end else begin : gBody
      assign valid_in = gStage[s-1].valid_q;
      assign data_in  = gStage[s-1].data_q;
      assign of_in    = gStage[s-1].of_q;
      assign sh_in    = gStage[s-1].gCtl.sh_q;
      assign mode_in  = gStage[s-1].gCtl.mode_q;
      assign sign_in  = gStage[s-1].gCtl.sign_q;
    end

    // ASL overflow at a level: the top 2^k+1 bits must all match, i.e. sign-extend to 0 or -1.
    always_comb begin
      data_d = data_in;
      of_d   = of_in;
      top    = '0;
      for (int k = FIRST; k < LAST; k++) begin
        if (sh_in[k]) begin
          case (mode_in)
            MODE_ASL: begin
              top    = $signed(data_d) >>> (WIDTH - 1 - (1 << k));
              of_d   = of_d | ((top != '0) && (top != '1));
              data_d = data_d << (1 << k);
            end
            MODE_ASR: data_d = $signed(data_d) >>> (1 << k);
            MODE_LSR: data_d = data_d >> (1 << k);
            default:  data_d = (data_d << (1 << k)) | (data_d >> (WIDTH - (1 << k)));
          endcase
        end
      end
      if (IS_LAST && (SATURATE != 0) && (mode_in == MODE_ASL) && of_d) begin
        data_d = sign_in ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        of_q    <= 1'b0;
      end else if (advance) begin
        valid_q <= valid_in;
        data_q  <= data_d;
        of_q    <= of_d;
      end
    end

    if (!IS_LAST) begin : gCtl
      logic [LOG-1:0] sh_q;
      mode_e          mode_q;
      logic           sign_q;

      // Mode, shift bits and the original sign ride along for the later levels and saturation.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_q   <= '0;
          mode_q <= MODE_ASL;
          sign_q <= 1'b0;
        end else if (advance) begin
          sh_q   <= sh_in;
          mode_q <= mode_in;
          sign_q <= sign_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_shift_pipe.sv
// Bench for signed_shift_pipe: three configurations fed one stream, each checked
// against a plain-arithmetic shift model with a per-instance scoreboard.
module tb_signed_shift_pipe;

  localparam int W  = 32;
  localparam int NI = 3;
  localparam int STG [NI] = '{2, 1, 5};
  localparam bit SAT [NI] = '{1'b0, 1'b0, 1'b1};

  typedef struct {
    int         stamp;
    logic [W-1:0] data;
    logic         of;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [4:0]   sh;
    logic [1:0]   mode;
  } beat_t;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid;
  logic [W-1:0] inA;
  logic [4:0]   inSh;
  logic [1:0]   inMode;
  logic         inReady  [NI];
  logic         outValid [NI];
  logic         outReady [NI];
  logic         outOf    [NI];
  logic [W-1:0] outData  [NI];

  int   cycle = 0;
  int   nChecks = 0;
  int   nFails = 0;
  exp_t expQ [NI][$];
  bit   trackOn, captureOn;
  bit   capGot [NI];
  logic [W-1:0] capData [NI];
  logic capOf [NI];
  int   capLat [NI];
  int   acceptStamp [NI];
  bit   lastAccept [NI];
  bit   lastPop [NI];
  int   popCount [NI];
  int   stallSeen [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  signed_shift_pipe #(.WIDTH(W), .STAGES(2), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady[0]),
    .in_a(inA), .in_sh(inSh), .in_mode(inMode), .out_valid(outValid[0]),
    .out_ready(outReady[0]), .out_data(outData[0]), .out_of(outOf[0]));

  signed_shift_pipe #(.WIDTH(W), .STAGES(1), .SATURATE(0)) dut1 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady[1]),
    .in_a(inA), .in_sh(inSh), .in_mode(inMode), .out_valid(outValid[1]),
    .out_ready(outReady[1]), .out_data(outData[1]), .out_of(outOf[1]));

  signed_shift_pipe #(.WIDTH(W), .STAGES(5), .SATURATE(1)) dut2 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady[2]),
    .in_a(inA), .in_sh(inSh), .in_mode(inMode), .out_valid(outValid[2]),
    .out_ready(outReady[2]), .out_data(outData[2]), .out_of(outOf[2]));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: ASL overflow means shifting back does not recover the operand.
  function automatic logic [W:0] refShift(input logic [W-1:0] a, input logic [4:0] sh,
                                         input logic [1:0] mode, input bit sat);
    logic [W-1:0]   r;
    logic           o;
    logic [2*W-1:0] dbl;
    o = 1'b0;
    case (mode)
      2'd0: begin
        r = a << sh;
        o = (($signed(r) >>> sh) != $signed(a));
        if (sat && o) r = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      2'd1: r = $signed(a) >>> sh;
      2'd2: r = a >> sh;
      default: begin
        dbl = {a, a} << sh;
        r   = dbl[2*W-1:W];
      end
    endcase
    return {o, r};
  endfunction

  // One clock: observe handshakes at the falling edge, then return just after the next rising edge.
  task automatic runCycle();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      lastAccept[i] = inValid && inReady[i];
      lastPop[i]    = outValid[i] && outReady[i];
      if (lastAccept[i]) acceptStamp[i] = cycle;
      if (trackOn) begin
        if (lastAccept[i]) begin
          e.stamp = cycle;
          {e.of, e.data} = refShift(inA, inSh, inMode, SAT[i]);
          expQ[i].push_back(e);
        end
        if (outValid[i] && !outReady[i]) begin
          stallSeen[i]++;
          checkOutput($sformatf("stall_in_ready%0d", i), 64'(inReady[i]), 64'd0);
          if (expQ[i].size() > 0)
            checkOutput($sformatf("stall_hold%0d", i), {outOf[i], outData[i]},
                        {expQ[i][0].of, expQ[i][0].data});
        end
        if (lastPop[i]) begin
          popCount[i]++;
          if (expQ[i].size() == 0) begin
            checkOutput($sformatf("spurious%0d", i), 64'd1, 64'd0);
          end else begin
            e = expQ[i].pop_front();
            checkOutput($sformatf("data%0d", i), outData[i], e.data);
            checkOutput($sformatf("of%0d", i), 64'(outOf[i]), 64'(e.of));
            if (i != 0) checkOutput($sformatf("latency%0d", i), 64'(cycle - e.stamp), 64'(STG[i]));
          end
        end
      end
      if (captureOn && outValid[i] && !capGot[i]) begin
        capGot[i]  = 1'b1;
        capData[i] = outData[i];
        capOf[i]   = outOf[i];
        capLat[i]  = cycle - acceptStamp[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    for (int i = 0; i < NI; i++) outReady[i] = 1'b1;
    repeat (n) runCycle();
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [4:0] sh, input logic [1:0] mode);
    for (int i = 0; i < NI; i++) begin
      capGot[i]   = 1'b0;
      capData[i]  = '0;
      capOf[i]    = 1'b0;
      capLat[i]   = 0;
      outReady[i] = 1'b1;
    end
    inValid = 1'b1; inA = a; inSh = sh; inMode = mode;
    captureOn = 1'b1;
    runCycle();
    inValid = 1'b0;
    for (int c = 0; c < 10; c++) runCycle();
    captureOn = 1'b0;
    for (int i = 0; i < NI; i++)
      if (!capGot[i]) checkOutput($sformatf("timeout%0d", i), 64'd0, 64'd1);
  endtask

  task automatic checkAll(input string tag, input logic [W-1:0] d01, input logic o01,
                          input logic [W-1:0] d2, input logic o2);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), capData[i], (i == 2) ? d2 : d01);
      checkOutput($sformatf("%s_of%0d", tag, i), 64'(capOf[i]), 64'((i == 2) ? o2 : o01));
      checkOutput($sformatf("%s_lat%0d", tag, i), 64'(capLat[i]), 64'(STG[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    beat_t        pending [$];
    beat_t        b;
    int           stallLeft;
    int           stale;
    logic [W-1:0] negA;

    rstN = 1'b0; inValid = 1'b0; inA = '0; inSh = '0; inMode = '0;
    trackOn = 1'b0; captureOn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      outReady[i] = 1'b1; popCount[i] = 0; stallSeen[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("rst_valid%0d", i), 64'(outValid[i]), 64'd0);
      checkOutput($sformatf("rst_data%0d", i), outData[i], 64'd0);
      checkOutput($sformatf("rst_of%0d", i), 64'(outOf[i]), 64'd0);
      checkOutput($sformatf("rst_in_ready%0d", i), 64'(inReady[i]), 64'd1);
    end
    rstN = 1'b1;
    idle(2);

    $display("[TB] directed vectors");
    applyStimulus(32'h0000_0003, 5'd30, 2'd0);
    checkAll("asl_of", 32'hC000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
    applyStimulus(32'hFFFF_FFF8, 5'd28, 2'd0);
    checkAll("asl_ok", 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0);
    negA = -893483234;
    applyStimulus(negA, 5'd23, 2'd1);
    checkAll("asr", 32'hFFFF_FF95, 1'b0, 32'hFFFF_FF95, 1'b0);
    applyStimulus(32'h8000_0000, 5'd31, 2'd2);
    checkAll("lsr_max", 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0);
    applyStimulus(32'h8000_0000, 5'd31, 2'd1);
    checkAll("asr_max", 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
    for (int m = 0; m < 4; m++) begin
      applyStimulus(32'h1234_5678, 5'd0, 2'(m));
      checkAll($sformatf("sh0_m%0d", m), 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);
    end
    applyStimulus(32'h8000_0001, 5'd1, 2'd3);
    checkAll("rol", 32'h0000_0003, 1'b0, 32'h0000_0003, 1'b0);
    applyStimulus(32'h4000_0000, 5'd1, 2'd0);
    checkAll("sat_pos", 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
    applyStimulus(32'hC000_0000, 5'd2, 2'd0);
    checkAll("sat_neg", 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b1);
    applyStimulus(32'h0000_0001, 5'd31, 2'd0);
    checkAll("asl_max_one", 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 5'd31, 2'd0);
    checkAll("asl_max_m1", 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0);

    $display("[TB] backpressure");
    trackOn = 1'b1;
    for (int i = 0; i < NI; i++) begin
      popCount[i] = 0; stallSeen[i] = 0;
    end
    for (int j = 0; j < 4; j++) begin
      b.a = $urandom(); b.sh = 5'($urandom()); b.mode = 2'($urandom());
      pending.push_back(b);
    end
    stallLeft = -1;
    for (int c = 0; c < 40; c++) begin
      inValid = (pending.size() > 0);
      if (inValid) begin
        inA = pending[0].a; inSh = pending[0].sh; inMode = pending[0].mode;
      end
      outReady[0] = !(stallLeft > 0);
      if (stallLeft > 0) stallLeft--;
      runCycle();
      if (lastAccept[0]) void'(pending.pop_front());
      if (lastPop[0] && stallLeft < 0) stallLeft = 5;
    end
    checkOutput("bp_results", 64'(popCount[0]), 64'd4);
    checkOutput("bp_stall_cycles", 64'(stallSeen[0]), 64'd5);
    checkOutput("bp_pending", 64'(pending.size()), 64'd0);

    $display("[TB] random stream");
    for (int c = 0; c < 1400; c++) begin
      inValid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       inA = '0;
        1:       inA = '1;
        2:       inA = 32'h0000_0001;
        3:       inA = 32'h8000_0000;
        default: inA = $urandom();
      endcase
      inSh   = 5'($urandom());
      inMode = 2'($urandom());
      outReady[0] = ($urandom_range(0, 3) != 0);
      runCycle();
    end
    idle(12);
    for (int i = 0; i < NI; i++)
      checkOutput($sformatf("drain%0d", i), 64'(expQ[i].size()), 64'd0);
    trackOn = 1'b0;

    $display("[TB] reset mid-operation");
    inValid = 1'b1; inA = 32'h0000_00F0; inSh = 5'd4; inMode = 2'd0;
    runCycle();
    inA = 32'h0F00_0000; inSh = 5'd8; inMode = 2'd3;
    runCycle();
    inValid = 1'b0;
    checkOutput("pre_reset_valid0", 64'(outValid[0]), 64'd1);
    #2 rstN = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("mid_rst_valid%0d", i), 64'(outValid[i]), 64'd0);
      checkOutput($sformatf("mid_rst_data%0d", i), outData[i], 64'd0);
      checkOutput($sformatf("mid_rst_of%0d", i), 64'(outOf[i]), 64'd0);
    end
    #2 rstN = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      runCycle();
      for (int i = 0; i < NI; i++) if (outValid[i]) stale++;
    end
    checkOutput("no_stale", 64'(stale), 64'd0);
    applyStimulus(32'h0000_0005, 5'd3, 2'd0);
    checkAll("post_rst", 32'h0000_0028, 1'b0, 32'h0000_0028, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
